// File: rtl/comparador_serial_nbits_if.sv
// rtl/comparador_serial_nbits_if.sv - start/operand request and result bundle for the serial comparator
interface comparador_serial_nbits_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         maior;
    logic         menor;
    logic         igual;

    modport master (
        output start, a, b,
        input  busy, done, maior, menor, igual
    );

    modport slave (
        input  start, a, b,
        output busy, done, maior, menor, igual
    );
endinterface

// File: rtl/comparador_serial_nbits.sv
// rtl/comparador_serial_nbits.sv - N-bit unsigned magnitude comparator using one 1-bit stage, MSB-first
module comparador_serial_nbits #(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    comparador_serial_nbits_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARA = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [CW-1:0] count;
    logic          busy_r;
    logic          done_r;
    logic          maior_r;
    logic          menor_r;
    logic          igual_r;

    logic bit_a;
    logic bit_b;

    assign bit_a = sa[N-1];
    assign bit_b = sb[N-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            count   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            maior_r <= 1'b0;
            menor_r <= 1'b0;
            igual_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa      <= bus.a;
                        sb      <= bus.b;
                        count   <= COUNT_INIT;
                        maior_r <= 1'b0;
                        menor_r <= 1'b0;
                        igual_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= COMPARA;
                    end
                end
                COMPARA: begin
                    // First differing bit from the MSB decides; equal bits keep shifting.
                    if (bit_a && !bit_b) begin
                        maior_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= FIM;
                    end else if (!bit_a && bit_b) begin
                        menor_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= FIM;
                    end else if (count == '0) begin
                        igual_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= FIM;
                    end else begin
                        sa    <= sa << 1;
                        sb    <= sb << 1;
                        count <= count - 1'b1;
                    end
                end
                FIM: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.maior = maior_r;
    assign bus.menor = menor_r;
    assign bus.igual = igual_r;
endmodule

// File: tb/tb_comparador_serial_nbits.sv
// tb/tb_comparador_serial_nbits.sv - scoreboard bench for comparador_serial_nbits with N=8
module tb_comparador_serial_nbits;
    localparam int N = 8;

    typedef struct {
        int         e0;
        int         lat;
        logic [2:0] res;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_count;
    int   checks;
    int   errors;
    exp_t q[$];

    comparador_serial_nbits_if #(.N(N)) bus ();

    comparador_serial_nbits #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_count = 0;
    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_count);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int e0);
        exp_t e;
        e.e0  = e0;
        e.lat = N + 1;
        for (int i = 0; i < N; i++)
            if (a[i] != b[i]) e.lat = N - i + 1;
        if (a > b)      e.res = 3'b100;
        else if (a < b) e.res = 3'b010;
        else            e.res = 3'b001;
        return e;
    endfunction

    // Monitor: per-cycle busy expectation and result/latency check on every done
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_busy;
            int   now;
            exp_busy = 1'b0;
            if (q.size() > 0) begin
                now = edge_count - q[0].e0 + 1;
                exp_busy = (now >= 1) && (now < q[0].lat);
            end
            chk("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", edge_count - e.e0 + 1, e.lat);
                    chk("result", {29'b0, bus.maior, bus.menor, bus.igual}, {29'b0, e.res});
                end
            end
        end
    end

    task automatic start_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic hold_start, input logic [N-1:0] a_next);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        q.push_back(model(a, b, edge_count + 1));
        @(negedge clk);
        chk("cleared_on_accept", {29'b0, bus.maior, bus.menor, bus.igual}, 32'd0);
        bus.start = hold_start;
        bus.a     = a_next;
        bus.b     = N'($urandom);
        if (hold_start) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        chk("done_seen", {31'b0, bus.done}, 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {27'b0, bus.busy, bus.done, bus.maior, bus.menor, bus.igual}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_cmp(8'h80, 8'h7F, 1'b0, 8'h00);
        wait_done();

        start_cmp(8'h12, 8'h13, 1'b0, 8'hFF);
        wait_done();

        start_cmp(8'hA5, 8'hA5, 1'b0, 8'h00);
        wait_done();
        repeat (5) @(negedge clk);
        chk("hold_igual", {29'b0, bus.maior, bus.menor, bus.igual}, 32'b001);

        // Start held while busy with a changed operand: must be ignored
        start_cmp(8'h40, 8'h00, 1'b1, 8'h00);
        wait_done();
        repeat (3) @(negedge clk);
        chk("hold_maior", {29'b0, bus.maior, bus.menor, bus.igual}, 32'b100);

        // Reset in cycle 4 aborts the compare
        start_cmp(8'h01, 8'h02, 1'b0, 8'h01);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {27'b0, bus.busy, bus.done, bus.maior, bus.menor, bus.igual}, 32'd0);
        q.delete();
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_abort_results", {29'b0, bus.maior, bus.menor, bus.igual}, 32'd0);

        // Back-to-back: second start in the cycle right after done
        start_cmp(8'h3C, 8'h3D, 1'b0, 8'h00);
        wait_done();
        start_cmp(8'hFF, 8'hFE, 1'b0, 8'h00);
        wait_done();

        start_cmp(8'h00, 8'h00, 1'b0, 8'h55);
        wait_done();
        start_cmp(8'hFF, 8'hFF, 1'b0, 8'h00);
        wait_done();
        start_cmp(8'h7F, 8'h80, 1'b0, 8'hFF);
        wait_done();

        for (int k = 0; k < 12; k++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = (k % 3 == 0) ? ra ^ N'(1 << $urandom_range(N - 1, 0)) : N'($urandom);
            start_cmp(ra, rb, 1'b0, N'($urandom));
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
